// File: rtl/bank_timing_fsm.sv
// bank_timing_fsm: per-bank DRAM command sequencer.
// Accepts one-hot DDR command strobes and enforces tRCD/tRAS/tRP/tWR/tRFC
// and burst length using saturating down-counters. The 5-bit state code is
// decoded by the bank datapath. All registers freeze while halt is high.
// Optional build macro: BANK_FSM_ILLEGAL_CMD_EN enables the sticky err flag
// for rejected commands; without it err is tied low.
module bank_timing_fsm #(
  parameter int ROWS = 131072,
  parameter int BL   = 8,
  parameter int TRCD = 4,
  parameter int TRAS = 10,
  parameter int TRP  = 4,
  parameter int TWR  = 4,
  parameter int TRFC = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    halt,
  input  logic                    ACT,
  input  logic                    PR,
  input  logic                    RD,
  input  logic                    RDA,
  input  logic                    WR,
  input  logic                    WRA,
  input  logic                    REF,
  input  logic [$clog2(ROWS)-1:0] row,
  output logic [4:0]              state,
  output logic                    cmd_ack,
  output logic [$clog2(ROWS)-1:0] open_row,
  output logic                    row_open,
  output logic                    err
);

  localparam int RW = $clog2(ROWS);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max_of(max_of(max_of(TRCD, TRAS), max_of(TRP, TWR)),
                               max_of(TRFC, BL));
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [4:0] {
    IDLE        = 5'b00000,
    ACTIVATING  = 5'b00001,
    BANK_ACTIVE = 5'b00010,
    READING     = 5'b01011,
    READING_AP  = 5'b01100,
    WRITING     = 5'b10010,
    WRITING_AP  = 5'b10011,
    WR_RECOVERY = 5'b10101,
    PRECHARGING = 5'b10100,
    REFRESHING  = 5'b11000
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   dwell_q, dwell_d;
  logic [TW-1:0]   tras_q, tras_d;
  logic [TW-1:0]   twr_q, twr_d;
  logic            cmd_ack_q;
  logic [RW-1:0]   open_row_q;
  logic            row_open_q;

  logic [6:0]      strobes;
  logic            one_cmd;
  logic            dwell_done;
  logic            tras_done;
  logic            twr_done;
  logic            accept;
  logic            load_row;
  logic            set_open;
  logic            clr_open;
  logic            col_ready;

  assign strobes    = {ACT, PR, RD, RDA, WR, WRA, REF};
  assign one_cmd    = (strobes != 7'd0) && ((strobes & (strobes - 7'd1)) == 7'd0);
  assign dwell_done = (dwell_q == '0);
  assign tras_done  = (tras_q == '0);
  assign twr_done   = (twr_q == '0);

  // Next-state, timer reloads and command acceptance for the current cycle.
  // An expired ACTIVATING behaves like BANK_ACTIVE so a column command can
  // be taken on the very edge that tRCD completes.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_done ? '0 : dwell_q - 1'b1;
    tras_d    = tras_done  ? '0 : tras_q - 1'b1;
    twr_d     = twr_done   ? '0 : twr_q - 1'b1;
    accept    = 1'b0;
    load_row  = 1'b0;
    set_open  = 1'b0;
    clr_open  = 1'b0;
    col_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (one_cmd && ACT) begin
          state_d  = ACTIVATING;
          dwell_d  = TW'(TRCD - 1);
          tras_d   = TW'(TRAS - 1);
          load_row = 1'b1;
          accept   = 1'b1;
        end else if (one_cmd && REF) begin
          state_d = REFRESHING;
          dwell_d = TW'(TRFC - 1);
          accept  = 1'b1;
        end
      end
      ACTIVATING: begin
        if (dwell_done) begin
          state_d   = BANK_ACTIVE;
          set_open  = 1'b1;
          col_ready = 1'b1;
        end
      end
      BANK_ACTIVE: begin
        col_ready = 1'b1;
      end
      READING: begin
        if (dwell_done) begin
          state_d = BANK_ACTIVE;
        end
      end
      WRITING: begin
        if (dwell_done) begin
          state_d = BANK_ACTIVE;
          twr_d   = TW'(TWR);
        end
      end
      READING_AP: begin
        if (dwell_done && tras_done) begin
          state_d  = PRECHARGING;
          dwell_d  = TW'(TRP - 1);
          clr_open = 1'b1;
        end
      end
      WRITING_AP: begin
        if (dwell_done) begin
          state_d = WR_RECOVERY;
          dwell_d = TW'(TWR - 1);
        end
      end
      WR_RECOVERY: begin
        if (dwell_done && tras_done) begin
          state_d  = PRECHARGING;
          dwell_d  = TW'(TRP - 1);
          clr_open = 1'b1;
        end
      end
      PRECHARGING: begin
        if (dwell_done) begin
          state_d = IDLE;
        end
      end
      REFRESHING: begin
        if (dwell_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (col_ready && one_cmd) begin
      if (RD) begin
        state_d = READING;
        dwell_d = TW'(BL - 1);
        accept  = 1'b1;
      end else if (RDA) begin
        state_d = READING_AP;
        dwell_d = TW'(BL - 1);
        accept  = 1'b1;
      end else if (WR) begin
        state_d = WRITING;
        dwell_d = TW'(BL - 1);
        accept  = 1'b1;
      end else if (WRA) begin
        state_d = WRITING_AP;
        dwell_d = TW'(BL - 1);
        accept  = 1'b1;
      end else if (PR && tras_done && twr_done) begin
        state_d  = PRECHARGING;
        dwell_d  = TW'(TRP - 1);
        clr_open = 1'b1;
        accept   = 1'b1;
      end
    end
  end

  // State, timers and status registers; reset wins over halt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dwell_q    <= '0;
      tras_q     <= '0;
      twr_q      <= '0;
      cmd_ack_q  <= 1'b0;
      open_row_q <= '0;
      row_open_q <= 1'b0;
    end else if (!halt) begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      tras_q    <= tras_d;
      twr_q     <= twr_d;
      cmd_ack_q <= accept;
      if (load_row) begin
        open_row_q <= row;
      end
      if (clr_open) begin
        row_open_q <= 1'b0;
      end else if (set_open) begin
        row_open_q <= 1'b1;
      end
    end
  end

`ifdef BANK_FSM_ILLEGAL_CMD_EN
  logic cmd_err;
  logic err_q;

  assign cmd_err = (strobes != 7'd0) && !accept;

  // Sticky flag for any strobe activity that was not accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (!halt && cmd_err) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign state    = state_q;
  assign cmd_ack  = cmd_ack_q;
  assign open_row = open_row_q;
  assign row_open = row_open_q;

endmodule

// File: tb/tb_bank_timing_fsm.sv
// tb_bank_timing_fsm: self-checking bench for bank_timing_fsm.
// The reference model tracks emulated time (edges with halt low) and
// timestamps of entries/ACT/write completion instead of down-counters.
module tb_bank_timing_fsm;

  localparam int ROWS = 131072;
  localparam int RW   = 17;
  localparam int BL   = 8;
  localparam int TRCD = 4;
  localparam int TRAS = 10;
  localparam int TRP  = 4;
  localparam int TWR  = 4;
  localparam int TRFC = 16;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_ACTV = 5'b00001;
  localparam logic [4:0] S_BA   = 5'b00010;
  localparam logic [4:0] S_RD   = 5'b01011;
  localparam logic [4:0] S_RDA  = 5'b01100;
  localparam logic [4:0] S_WR   = 5'b10010;
  localparam logic [4:0] S_WRA  = 5'b10011;
  localparam logic [4:0] S_WREC = 5'b10101;
  localparam logic [4:0] S_PRE  = 5'b10100;
  localparam logic [4:0] S_REF  = 5'b11000;

  // Strobe vector order: {ACT, PR, RD, RDA, WR, WRA, REF}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ACT  = 7'b1000000;
  localparam logic [6:0] C_PR   = 7'b0100000;
  localparam logic [6:0] C_RD   = 7'b0010000;
  localparam logic [6:0] C_RDA  = 7'b0001000;
  localparam logic [6:0] C_WR   = 7'b0000100;
  localparam logic [6:0] C_WRA  = 7'b0000010;
  localparam logic [6:0] C_REF  = 7'b0000001;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          halt;
  logic          ACT, PR, RD, RDA, WR, WRA, REF;
  logic [RW-1:0] row;
  logic [4:0]    state;
  logic          cmd_ack;
  logic [RW-1:0] open_row;
  logic          row_open;
  logic          err;

  int check_count = 0;
  int error_count = 0;

  // Reference model state
  logic [4:0]    m_state;
  logic          m_ack;
  logic [RW-1:0] m_open_row;
  logic          m_row_open;
  logic          m_err;
  int            m_t;
  int            m_entry_t;
  int            m_act_t;
  int            m_twr_ok_t;

  always #5 clk = ~clk;

  bank_timing_fsm #(
    .ROWS(ROWS), .BL(BL), .TRCD(TRCD), .TRAS(TRAS),
    .TRP(TRP), .TWR(TWR), .TRFC(TRFC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .halt(halt),
    .ACT(ACT),
    .PR(PR),
    .RD(RD),
    .RDA(RDA),
    .WR(WR),
    .WRA(WRA),
    .REF(REF),
    .row(row),
    .state(state),
    .cmd_ack(cmd_ack),
    .open_row(open_row),
    .row_open(row_open),
    .err(err)
  );

  // How long each timed state is held, in emulated cycles.
  function automatic int duration(input logic [4:0] code);
    case (code)
      S_ACTV:                    return TRCD;
      S_RD, S_RDA, S_WR, S_WRA:  return BL;
      S_WREC:                    return TWR;
      S_PRE:                     return TRP;
      S_REF:                     return TRFC;
      default:                   return 0;
    endcase
  endfunction

  // Counts one comparison and reports it if it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advances the reference model by one clock edge with the given inputs.
  task automatic modelStep(input logic [6:0] cmd, input logic [RW-1:0] row_val,
                           input logic halt_val, input logic rst_val);
    int         n;
    logic       done, ras_ok, wr_ok, col, acc;
    logic [4:0] nxt;
    if (!rst_val) begin
      m_state    = S_IDLE;
      m_ack      = 1'b0;
      m_open_row = '0;
      m_row_open = 1'b0;
      m_err      = 1'b0;
      m_t        = 0;
      m_entry_t  = 0;
      m_act_t    = -100000;
      m_twr_ok_t = 0;
      return;
    end
    if (halt_val) return;
    n      = $countones(cmd);
    done   = (m_t >= m_entry_t + duration(m_state));
    ras_ok = (m_t >= m_act_t + TRAS);
    wr_ok  = (m_t >= m_twr_ok_t);
    col    = 1'b0;
    acc    = 1'b0;
    nxt    = m_state;
    case (m_state)
      S_IDLE: begin
        if (n == 1 && cmd == C_ACT) begin
          nxt = S_ACTV; acc = 1'b1; m_act_t = m_t; m_open_row = row_val;
        end else if (n == 1 && cmd == C_REF) begin
          nxt = S_REF; acc = 1'b1;
        end
      end
      S_ACTV: if (done) begin nxt = S_BA; m_row_open = 1'b1; col = 1'b1; end
      S_BA:   col = 1'b1;
      S_RD:   if (done) nxt = S_BA;
      S_WR:   if (done) begin nxt = S_BA; m_twr_ok_t = m_t + TWR + 1; end
      S_RDA:  if (done && ras_ok) nxt = S_PRE;
      S_WRA:  if (done) nxt = S_WREC;
      S_WREC: if (done && ras_ok) nxt = S_PRE;
      S_PRE:  if (done) nxt = S_IDLE;
      S_REF:  if (done) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (col && n == 1) begin
      if (cmd == C_RD)       begin nxt = S_RD;  acc = 1'b1; end
      else if (cmd == C_RDA) begin nxt = S_RDA; acc = 1'b1; end
      else if (cmd == C_WR)  begin nxt = S_WR;  acc = 1'b1; end
      else if (cmd == C_WRA) begin nxt = S_WRA; acc = 1'b1; end
      else if (cmd == C_PR && ras_ok && wr_ok) begin nxt = S_PRE; acc = 1'b1; end
    end
    if (nxt != m_state) m_entry_t = m_t;
    if (nxt == S_PRE && m_state != S_PRE) m_row_open = 1'b0;
    m_ack = acc;
`ifdef BANK_FSM_ILLEGAL_CMD_EN
    if (n > 0 && !acc) m_err = 1'b1;
`endif
    m_state = nxt;
    m_t++;
  endtask

  // Drives one cycle of inputs, steps the model, and compares after the edge.
  task automatic applyStimulus(input logic [6:0] cmd, input logic [RW-1:0] row_val,
                               input logic halt_val, input logic rst_val);
    @(negedge clk);
    {ACT, PR, RD, RDA, WR, WRA, REF} = cmd;
    row     = row_val;
    halt    = halt_val;
    reset_n = rst_val;
    modelStep(cmd, row_val, halt_val, rst_val);
    @(posedge clk);
    #1;
    checkOutput("state",    {27'd0, state},    {27'd0, m_state});
    checkOutput("cmd_ack",  {31'd0, cmd_ack},  {31'd0, m_ack});
    checkOutput("open_row", {15'd0, open_row}, {15'd0, m_open_row});
    checkOutput("row_open", {31'd0, row_open}, {31'd0, m_row_open});
    checkOutput("err",      {31'd0, err},      {31'd0, m_err});
  endtask

  task automatic idleCycles(input int count);
    for (int i = 0; i < count; i++) applyStimulus(C_NONE, '0, 1'b0, 1'b1);
  endtask

  // Directed scenarios followed by a long randomized run.
  initial begin
    logic [6:0]    rcmd;
    logic [RW-1:0] rrow;
    logic          rhalt, rrst;
    int            r, sh;

    reset_n = 1'b0;
    halt    = 1'b0;
    {ACT, PR, RD, RDA, WR, WRA, REF} = C_NONE;
    row     = '0;

    applyStimulus(C_NONE, '0, 1'b0, 1'b0);
    applyStimulus(C_NONE, '0, 1'b0, 1'b0);
    checkOutput("reset_code", {27'd0, state}, 32'd0);

    // ACT with row 0x1A5, then tRCD, early PR, a read burst and a legal PR
    applyStimulus(C_ACT, 17'h1A5, 1'b0, 1'b1);
    checkOutput("act_code", {27'd0, state}, {27'd0, S_ACTV});
    idleCycles(4);
    checkOutput("active_code", {27'd0, state}, {27'd0, S_BA});
    checkOutput("open_row_1a5", {15'd0, open_row}, 32'h1A5);
    applyStimulus(C_PR, '0, 1'b0, 1'b1);
    applyStimulus(C_RD, '0, 1'b0, 1'b1);
    idleCycles(8);
    applyStimulus(C_PR, '0, 1'b0, 1'b1);
    idleCycles(5);

    // Write with auto-precharge after tRAS has expired
    applyStimulus(C_ACT, 17'h0F0F0, 1'b0, 1'b1);
    idleCycles(12);
    applyStimulus(C_WRA, '0, 1'b0, 1'b1);
    idleCycles(18);

    // Refresh with an ignored read in the middle
    applyStimulus(C_REF, '0, 1'b0, 1'b1);
    idleCycles(3);
    applyStimulus(C_RD, '0, 1'b0, 1'b1);
    idleCycles(14);

    // Halt in the middle of a read burst, with a strobe dropped while halted
    applyStimulus(C_ACT, 17'h00033, 1'b0, 1'b1);
    idleCycles(4);
    applyStimulus(C_RD, '0, 1'b0, 1'b1);
    idleCycles(3);
    for (int i = 0; i < 5; i++)
      applyStimulus((i == 2) ? C_RD : C_NONE, '0, 1'b1, 1'b1);
    idleCycles(10);

    // Reset mid-burst while halted
    applyStimulus(C_ACT, 17'h1FFFF, 1'b0, 1'b1);
    idleCycles(4);
    applyStimulus(C_RD, '0, 1'b0, 1'b1);
    idleCycles(2);
    applyStimulus(C_NONE, '0, 1'b1, 1'b0);
    checkOutput("midburst_reset", {27'd0, state}, 32'd0);

    // Double strobe, then write recovery gating PR
    applyStimulus(C_ACT | C_REF, 17'h00001, 1'b0, 1'b1);
    applyStimulus(C_ACT, 17'h12345, 1'b0, 1'b1);
    idleCycles(12);
    applyStimulus(C_WR, '0, 1'b0, 1'b1);
    idleCycles(8);
    applyStimulus(C_PR, '0, 1'b0, 1'b1);
    idleCycles(2);
    applyStimulus(C_PR, '0, 1'b0, 1'b1);
    idleCycles(3);
    applyStimulus(C_PR, '0, 1'b0, 1'b1);
    idleCycles(6);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r    = $urandom_range(0, 99);
      rcmd = C_NONE;
      if (r < 35) begin
        sh   = $urandom_range(0, 6);
        rcmd = 7'(1 << sh);
      end else if (r < 38) begin
        rcmd = 7'($urandom_range(1, 127));
      end
      rrow  = RW'($urandom_range(0, ROWS - 1));
      rhalt = ($urandom_range(0, 99) < 6);
      rrst  = ($urandom_range(0, 299) != 0);
      applyStimulus(rcmd, rrow, rhalt, rrst);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
